// File: rtl/vga_pkg.sv
// Shared VGA constants and the per-axis DDA state record used by the sprite
// address sequencer.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;

  // Storage widths for one DDA axis; instances check their needs fit.
  localparam int DDA_POS_W = 16;
  localparam int DDA_ACC_W = 12;

  typedef struct packed {
    logic [DDA_POS_W-1:0] pos;
    logic [DDA_ACC_W-1:0] acc;
    logic                 lock;
  } dda_state_t;

endpackage

// File: rtl/dda_axis.sv
// One axis of the incremental scaler: a remainder accumulator that advances
// pos by INC each time SRC/DST worth of source texels has been consumed.
module dda_axis
  import vga_pkg::*;
#(
  parameter int SRC   = 100,
  parameter int DST   = 210,
  parameter int INC   = 1,
  parameter int POS_W = 14,
  parameter int ACC_W = $clog2(DST + SRC) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             unlock,
  output logic [POS_W-1:0] pos,
  output logic [ACC_W-1:0] acc,
  output logic             lock,
  output logic             lock_next
);

  localparam logic [DDA_ACC_W-1:0] SRC_V = DDA_ACC_W'(SRC);
  localparam logic [DDA_ACC_W-1:0] DST_V = DDA_ACC_W'(DST);
  localparam logic [DDA_POS_W-1:0] INC_V = DDA_POS_W'(INC);

  if (SRC > DST) begin : g_chk_ratio
    $error("dda_axis: SRC must not exceed DST");
  end
  if (ACC_W > DDA_ACC_W) begin : g_chk_acc
    $error("dda_axis: accumulator does not fit dda_state_t");
  end
  if (POS_W > DDA_POS_W) begin : g_chk_pos
    $error("dda_axis: position does not fit dda_state_t");
  end

  dda_state_t           state_q;
  dda_state_t           state_d;
  logic [DDA_ACC_W-1:0] acc_sum;

  // SRC <= DST guarantees at most one carry per step, so a single compare suffices.
  always_comb begin
    state_d = state_q;
    acc_sum = state_q.acc + SRC_V;
    if (load) begin
      state_d.pos  = '0;
      state_d.acc  = '0;
      state_d.lock = 1'b1;
    end else if (step) begin
      if (acc_sum >= DST_V) begin
        state_d.pos = state_q.pos + INC_V;
        state_d.acc = acc_sum - DST_V;
      end else begin
        state_d.acc = acc_sum;
      end
    end else if (unlock) begin
      state_d.lock = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // pos/acc expose the post-edge view so the top can register the address directly.
  assign pos       = POS_W'(state_d.pos);
  assign acc       = ACC_W'(state_d.acc);
  assign lock      = state_q.lock;
  assign lock_next = state_d.lock;

endmodule

// File: rtl/sprite_scale_addr_gen.sv
// Scan-following ROM address generator for a scaled full-image sprite; output
// address is registered one cycle after DrawX/DrawY, pix_en one cycle later.
module sprite_scale_addr_gen
  import vga_pkg::*;
#(
  parameter int SRC_W  = 100,
  parameter int SRC_H  = 100,
  parameter int DST_W  = 210,
  parameter int DST_H  = 220,
  parameter int DST_X0 = 0,
  parameter int DST_Y0 = 140,
  parameter int ADDR_W = 14
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_address,
  output logic              addr_valid,
  output logic              pix_en
);

  localparam int X_ACC_W = $clog2(DST_W + SRC_W) + 1;
  localparam int Y_ACC_W = $clog2(DST_H + SRC_H) + 1;

  if (SRC_W * SRC_H > (1 << ADDR_W)) begin : g_chk_addr
    $error("sprite_scale_addr_gen: ADDR_W too small for SRC_W*SRC_H");
  end
  if (DST_X0 + DST_W > H_ACTIVE || DST_Y0 + DST_H > V_ACTIVE) begin : g_chk_win
    $error("sprite_scale_addr_gen: window exceeds the active display");
  end

  logic              x_load, x_step, x_unlock;
  logic              y_line, y_load, y_step, y_unlock;
  logic              xlock_q, xlock_next, ylock_q, ylock_next;
  logic [ADDR_W-1:0] col_next, row_next;
  logic [X_ACC_W-1:0] xacc_unused;
  logic [Y_ACC_W-1:0] yacc_unused;
  logic              in_win, hit;

  logic [9:0]        x_prev_q, x_prev_d;
  logic [9:0]        y_prev_q, y_prev_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              addr_valid_q, addr_valid_d;
  logic              blank_d1_q, blank_d1_d;
  logic              pix_en_q, pix_en_d;

  // Axis control: X every edge, Y only on the DrawX==0 edge of each line.
  always_comb begin
    x_load   = (int'(DrawX) == DST_X0);
    x_step   = !x_load && xlock_q && ({1'b0, DrawX} == {1'b0, x_prev_q} + 11'd1);
    x_unlock = !x_load && !x_step;
    y_line   = (DrawX == 10'd0);
    y_load   = y_line && (int'(DrawY) == DST_Y0);
    y_step   = y_line && !y_load && ylock_q && ({1'b0, DrawY} == {1'b0, y_prev_q} + 11'd1);
    y_unlock = y_line && !y_load && !y_step && (DrawY != y_prev_q);
    x_prev_d = DrawX;
    y_prev_d = y_line ? DrawY : y_prev_q;
  end

  dda_axis #(
    .SRC   (SRC_W),
    .DST   (DST_W),
    .INC   (1),
    .POS_W (ADDR_W),
    .ACC_W (X_ACC_W)
  ) u_x_axis (
    .clk       (vga_clk),
    .rst       (Reset),
    .load      (x_load),
    .step      (x_step),
    .unlock    (x_unlock),
    .pos       (col_next),
    .acc       (xacc_unused),
    .lock      (xlock_q),
    .lock_next (xlock_next)
  );

  dda_axis #(
    .SRC   (SRC_H),
    .DST   (DST_H),
    .INC   (SRC_W),
    .POS_W (ADDR_W),
    .ACC_W (Y_ACC_W)
  ) u_y_axis (
    .clk       (vga_clk),
    .rst       (Reset),
    .load      (y_load),
    .step      (y_step),
    .unlock    (y_unlock),
    .pos       (row_next),
    .acc       (yacc_unused),
    .lock      (ylock_q),
    .lock_next (ylock_next)
  );

  // Outputs use the post-edge axis state, so a same-edge X and Y load combine.
  always_comb begin
    in_win        = (int'(DrawX) >= DST_X0) && (int'(DrawX) < DST_X0 + DST_W) &&
                    (int'(DrawY) >= DST_Y0) && (int'(DrawY) < DST_Y0 + DST_H);
    hit           = in_win && xlock_next && ylock_next;
    rom_address_d = hit ? (row_next + col_next) : '0;
    addr_valid_d  = hit;
    blank_d1_d    = blank;
    pix_en_d      = addr_valid_q && blank_d1_q;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_prev_q      <= '0;
      y_prev_q      <= '0;
      rom_address_q <= '0;
      addr_valid_q  <= 1'b0;
      blank_d1_q    <= 1'b0;
      pix_en_q      <= 1'b0;
    end else begin
      x_prev_q      <= x_prev_d;
      y_prev_q      <= y_prev_d;
      rom_address_q <= rom_address_d;
      addr_valid_q  <= addr_valid_d;
      blank_d1_q    <= blank_d1_d;
      pix_en_q      <= pix_en_d;
    end
  end

  assign rom_address = rom_address_q;
  assign addr_valid  = addr_valid_q;
  assign pix_en      = pix_en_q;

endmodule

// File: doc/sprite_scale_addr_gen.md
# sprite_scale_addr_gen

Incremental address sequencer for a scaled full-image sprite ROM (title or background art). It tracks the VGA scan position (DrawX, DrawY) and uses per-axis DDA accumulators to produce the source-ROM address for each screen pixel. This replaces the per-pixel multiply/divide address arithmetic. It sits between the VGA controller and the sprite ROM/palette pair, and supplies enables aligned to the ROM's one-cycle read latency.

## Interface
- SRC_W, 100: source image width in texels; must be ≤ DST_W.
- SRC_H, 100: source image height; must be ≤ DST_H.
- DST_W, 210: on-screen width in pixels.
- DST_H, 220: on-screen height in pixels.
- DST_X0, 0: screen X of the window's left edge.
- DST_Y0, 140: screen Y of the window's top edge.
- ADDR_W, 14: ROM address width; SRC_W·SRC_H ≤ 2^ADDR_W.
- vga_clk  in  1  pixel clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current scan X from the VGA controller.
- DrawY  in  10  current scan Y.
- blank  in  1  1 = active video (display enable).
- rom_address  out  ADDR_W  ROM address for the pixel sampled at the previous edge; registered.
- addr_valid  out  1  rom_address is inside the window and locked; same cycle as rom_address.
- pix_en  out  1  addr_valid & blank, delayed 1 cycle; aligned with ROM q.

## Operation
- The X axis holds state col (texel column), xacc (remainder, 0..DST_W-1), x_prev and xlock.
- The Y axis holds state row_base (row·SRC_W), yacc, y_prev and ylock.
- X update, evaluated at each edge:
  - If DrawX == DST_X0: col←0, xacc←0, xlock←1.
  - Else if xlock and DrawX == x_prev+1: t = xacc+SRC_W. If t ≥ DST_W then col++ and xacc←t−DST_W; otherwise xacc←t.
  - Else: xlock←0.
  - x_prev←DrawX in every case.
- Y update, evaluated only at edges where DrawX == 0:
  - If DrawY == DST_Y0: row_base←0, yacc←0, ylock←1.
  - Else if ylock and DrawY == y_prev+1: step as for X using SRC_H/DST_H. On carry, row_base += SRC_W.
  - Else if DrawY ≠ y_prev: ylock←0.
  - y_prev←DrawY.
- in_win = DrawX∈[DST_X0, DST_X0+DST_W) and DrawY∈[DST_Y0, DST_Y0+DST_H). The comparison is unsigned; no wrap from subtraction.
- Registered outputs:
  - rom_address ← row_base_next + col_next when in_win & xlock_next & ylock_next; otherwise 0.
  - addr_valid ← the same condition.
- pix_en ← addr_valid & blank_d1, where blank_d1 is blank registered once.
- Required result: rom_address equals ⌊(x−X0)·SRC_W/DST_W⌋ + ⌊(y−Y0)·SRC_H/DST_H⌋·SRC_W for every in-window pixel of a contiguous scan.
- Because SRC ≤ DST, there is at most one carry per step. xacc and yacc are $clog2(DST+SRC)+1 bits wide.
- No multipliers or dividers are allowed.
- Parameter violations are caught by elaboration-time assertions.

## Timing
- Latency:
  - Edge k samples DrawX/DrawY.
  - rom_address and addr_valid are valid after edge k.
  - The ROM registers the address at edge k+1, and q is valid after k+1, together with pix_en.
  - The downstream colour register captures at k+2.
- Reset values: rom_address=0, addr_valid=0, pix_en=0. All accumulators, col and row_base are 0. xlock=ylock=0. x_prev and y_prev are 0.
- After reset mid-frame, addr_valid stays 0 until the next scan reaches DrawY==DST_Y0 at DrawX==0, which is at most one frame later.
- A non-contiguous DrawX jump clears xlock until the next DrawX==DST_X0. Outputs are 0 meanwhile.
- If DrawX==DST_X0 and DrawX==0 on the same edge, both axis updates apply. The X load uses the Y state that is updated on that same edge.
- Reset has priority over all updates.

## Structure
- Shared package vga_pkg holds the H_ACTIVE=640 and V_ACTIVE=480 constants and the dda_state_t struct {pos, acc, lock}.
- Sub-module dda_axis (parameters SRC and DST; step, load and unlock inputs; pos and acc outputs) is instantiated once for X and once for Y.
  - The Y instance's pos increment is SRC_W; the X instance's is 1.
- The top level contains the window compare, the lock logic, the output registers and the blank delay.

## Test plan
- Reset, then a full frame (DrawX 0..799, DrawY 0..524) → (x=0,y=140) gives rom_address 0 and addr_valid 1 one cycle later; (x=209,y=359) gives 9999; (x=3,y=141) gives 1; (x=0,y=143) gives 100.
- DrawY=139 or DrawX=210 → addr_valid 0, rom_address 0, pix_en 0 on the following cycle.
- Full-frame sweep with a scoreboard comparing against the floor formula → zero mismatches; pix_en equals addr_valid delayed by 1 cycle and gated with blank.
- Reset asserted at DrawY=200 → addr_valid 0 for the rest of the frame; first addr_valid=1 at (0,140) of the next frame.
- DrawX jumps from 50 to 60 mid-line → addr_valid 0 from x=60 to the line end; resumes with correct addresses on the next line.
- blank=0 inside the window → addr_valid 1 but pix_en 0 the next cycle.
